// File: rtl/lfsr_seq_pkg.sv
// Shared state encoding and command priority for the LFSR command sequencer.
// Build option: LFSR_SEQ_RUN_EN enables the timed free-run mode.
package lfsr_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_STEP  = 3'd2;
  localparam state_t S_BURST = 3'd3;
  localparam state_t S_RUN   = 3'd4;
  localparam state_t S_FAULT = 3'd5;

  // bit index doubles as priority rank: higher index wins
  localparam int C_RUN   = 0;
  localparam int C_BURST = 1;
  localparam int C_STEP  = 2;
  localparam int C_LOAD  = 3;

  function automatic logic [3:0] cmd_pick(input logic [3:0] req);
    logic [3:0] one_hot;
    one_hot = '0;
    if (req[C_LOAD])
      one_hot[C_LOAD] = 1'b1;
    else if (req[C_STEP])
      one_hot[C_STEP] = 1'b1;
    else if (req[C_BURST])
      one_hot[C_BURST] = 1'b1;
    else if (req[C_RUN])
      one_hot[C_RUN] = 1'b1;
    return one_hot;
  endfunction

endpackage

// File: rtl/lfsr_seq_tick_gen.sv
// Clear-able prescaler: counts 0..COUNT-1 while enabled, tick on the wrap cycle.
// Only built when LFSR_SEQ_RUN_EN is defined.
module lfsr_seq_tick_gen #(
  parameter int unsigned COUNT = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W = (COUNT > 2) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/lfsr_sequencer.sv
// Command sequencer driving LFSR seed-load and step strobes.
// Build option: LFSR_SEQ_RUN_EN adds the timed free-run state.
module lfsr_sequencer
  import lfsr_seq_pkg::*;
#(
  parameter int unsigned COUNT      = 500_000,
  parameter int          BURST_W    = 8,
  parameter int          STEP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_load,
  input  logic                  cmd_step,
  input  logic                  cmd_burst,
  input  logic                  cmd_run,
  input  logic [BURST_W-1:0]    burst_len,
  input  logic                  lfsr_error,
  output logic                  seed_load,
  output logic                  lfsr_step,
  output logic                  busy,
  output logic                  fault,
  output logic [STEP_CNT_W-1:0] step_count
);

  logic [3:0] cmd;
  state_t state;
  state_t state_n;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_cnt_n;
  logic step_n;
  logic busy_n;

  assign cmd = cmd_pick({cmd_load, cmd_step, cmd_burst, cmd_run});

`ifdef LFSR_SEQ_RUN_EN
  logic tick;
  logic tick_clr;

  lfsr_seq_tick_gen #(
    .COUNT(COUNT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clr),
    .en   (state == S_RUN),
    .tick (tick)
  );
`else
  logic unused_run;
  assign unused_run = cmd[C_RUN] | (COUNT < 2);
`endif

  always_comb begin
    state_n     = state;
    burst_cnt_n = burst_cnt;
    step_n      = 1'b0;
`ifdef LFSR_SEQ_RUN_EN
    tick_clr    = 1'b0;
`endif
    // error outranks every command and swallows any pending step
    if (lfsr_error && state != S_LOAD && state != S_FAULT) begin
      state_n = S_FAULT;
    end else begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            cmd[C_LOAD]: state_n = S_LOAD;
            cmd[C_STEP]: begin
              state_n = S_STEP;
              step_n  = 1'b1;
            end
            cmd[C_BURST]: begin
              if (burst_len != '0) begin
                state_n     = S_BURST;
                step_n      = 1'b1;
                burst_cnt_n = burst_len;
              end
            end
`ifdef LFSR_SEQ_RUN_EN
            cmd[C_RUN]: begin
              state_n  = S_RUN;
              tick_clr = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        S_LOAD, S_STEP: state_n = S_IDLE;
        S_BURST: begin
          if (cmd[C_LOAD]) begin
            state_n = S_LOAD;
          end else if (burst_cnt == BURST_W'(1)) begin
            state_n = S_IDLE;
          end else begin
            step_n      = 1'b1;
            burst_cnt_n = burst_cnt - BURST_W'(1);
          end
        end
`ifdef LFSR_SEQ_RUN_EN
        S_RUN: begin
          if (cmd[C_LOAD])
            state_n = S_LOAD;
          else if (cmd[C_RUN])
            state_n = S_IDLE;
          else if (tick)
            step_n = 1'b1;
        end
`endif
        S_FAULT: begin
          if (cmd[C_LOAD])
            state_n = S_LOAD;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_n = (state_n == S_BURST);
`ifdef LFSR_SEQ_RUN_EN
    busy_n = busy_n || (state_n == S_RUN);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      burst_cnt  <= '0;
      seed_load  <= 1'b0;
      lfsr_step  <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      step_count <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_cnt_n;
      seed_load <= (state_n == S_LOAD);
      lfsr_step <= step_n;
      busy      <= busy_n;
      fault     <= (state_n == S_FAULT);
      if (state_n == S_LOAD)
        step_count <= '0;
      else if (step_n)
        step_count <= step_count + STEP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Scoreboard bench for lfsr_sequencer with COUNT=4.
// Free-run checks follow LFSR_SEQ_RUN_EN; otherwise cmd_run must be ignored.
module tb_lfsr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_load;
  logic        cmd_step;
  logic        cmd_burst;
  logic        cmd_run;
  logic [7:0]  burst_len;
  logic        lfsr_error;
  logic        seed_load;
  logic        lfsr_step;
  logic        busy;
  logic        fault;
  logic [15:0] step_count;

  lfsr_sequencer #(
    .COUNT(4),
    .BURST_W(8),
    .STEP_CNT_W(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_load  (cmd_load),
    .cmd_step  (cmd_step),
    .cmd_burst (cmd_burst),
    .cmd_run   (cmd_run),
    .burst_len (burst_len),
    .lfsr_error(lfsr_error),
    .seed_load (seed_load),
    .lfsr_step (lfsr_step),
    .busy      (busy),
    .fault     (fault),
    .step_count(step_count)
  );

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       bu;
    logic       ru;
    logic       er;
    logic [7:0] len;
  } stim_t;

  typedef struct packed {
    logic        sl;
    logic        st;
    logic        bz;
    logic        ft;
    logic [15:0] cnt;
  } obs_t;

  localparam stim_t NONE = '0;

  stim_t       stim_q[$];
  obs_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] ref_cnt = '0;

  function automatic stim_t sv(input logic ld, input logic st,
                               input logic bu, input logic ru,
                               input logic er, input logic [7:0] len);
    return {ld, st, bu, ru, er, len};
  endfunction

  // step_count reference: strobes seen since the last seed load
  task automatic sched(input stim_t s, input logic sl, input logic st,
                       input logic bz, input logic ft);
    if (sl) ref_cnt = '0;
    if (st) ref_cnt = ref_cnt + 16'd1;
    stim_q.push_back(s);
    exp_q.push_back({sl, st, bz, ft, ref_cnt});
  endtask

  task automatic apply(input stim_t s);
    cmd_load   = s.ld;
    cmd_step   = s.st;
    cmd_burst  = s.bu;
    cmd_run    = s.ru;
    lfsr_error = s.er;
    burst_len  = s.len;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    return {seed_load, lfsr_step, busy, fault, step_count};
  endfunction

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    apply(NONE);
    tick();
    tick();
    o = observe();
    n_vec++;
    if (o !== obs_t'('0)) begin
      n_bad++;
      $display("FAIL reset_held: got %h want %h", o, obs_t'('0));
    end
    reset = 1'b0;
    ref_cnt = '0;
    tick();
    o = observe();
    n_vec++;
    if (o !== obs_t'('0)) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", o, obs_t'('0));
    end
  endtask

  task automatic test_load_step();
    stim_t s;
    obs_t e, o;
    int i;
    sched(sv(1, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    sched(sv(0, 1, 0, 0, 0, 0), 0, 1, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      o = observe();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL load_step[%0d]: got %h want %h", i, o, e);
      end
      i++;
    end
    apply(NONE);
  endtask

  task automatic test_burst();
    stim_t s;
    obs_t e, o;
    int i;
    sched(sv(1, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    sched(sv(0, 0, 1, 0, 0, 5), 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) sched(NONE, 0, 1, 1, 0);
    sched(NONE, 0, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      o = observe();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL burst5[%0d]: got %h want %h", i, o, e);
      end
      i++;
    end
    apply(NONE);
  endtask

  task automatic test_burst_zero();
    stim_t s;
    obs_t e, o;
    int i;
    sched(sv(0, 0, 1, 0, 0, 0), 0, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      o = observe();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL burst0[%0d]: got %h want %h", i, o, e);
      end
      i++;
    end
    apply(NONE);
  endtask

  task automatic test_run();
    stim_t s;
    obs_t e, o;
    int i;
`ifdef LFSR_SEQ_RUN_EN
    sched(sv(0, 0, 0, 1, 0, 0), 0, 0, 1, 0);
    for (int k = 1; k <= 12; k++) sched(NONE, 0, (k % 4) == 0, 1, 0);
    sched(sv(0, 0, 0, 1, 0, 0), 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) sched(NONE, 0, 0, 0, 0);
`else
    sched(sv(0, 0, 0, 1, 0, 0), 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) sched(NONE, 0, 0, 0, 0);
`endif
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      o = observe();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL run[%0d]: got %h want %h", i, o, e);
      end
      i++;
    end
    apply(NONE);
  endtask

  task automatic test_fault();
    stim_t s;
    obs_t e, o;
    int i;
    sched(sv(1, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    sched(sv(0, 0, 1, 0, 0, 10), 0, 1, 1, 0);
    sched(NONE, 0, 1, 1, 0);
    sched(NONE, 0, 1, 1, 0);
    sched(sv(0, 0, 0, 0, 1, 0), 0, 0, 0, 1);
    sched(sv(0, 1, 0, 0, 0, 0), 0, 0, 0, 1);
    sched(sv(0, 0, 1, 0, 0, 2), 0, 0, 0, 1);
    sched(sv(0, 0, 0, 1, 0, 0), 0, 0, 0, 1);
    sched(NONE, 0, 0, 0, 1);
    sched(sv(1, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      o = observe();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL fault[%0d]: got %h want %h", i, o, e);
      end
      i++;
    end
    apply(NONE);
  endtask

  task automatic test_priority_reset();
    stim_t s;
    obs_t e, o;
    int i;
    sched(sv(1, 1, 0, 0, 0, 0), 1, 0, 0, 0);
    sched(NONE, 0, 0, 0, 0);
    sched(sv(0, 1, 1, 1, 0, 3), 0, 1, 0, 0);
    sched(NONE, 0, 0, 0, 0);
`ifdef LFSR_SEQ_RUN_EN
    sched(sv(0, 0, 0, 1, 0, 0), 0, 0, 1, 0);
    sched(NONE, 0, 0, 1, 0);
    sched(NONE, 0, 0, 1, 0);
    sched(NONE, 0, 0, 1, 0);
    sched(NONE, 0, 1, 1, 0);
    sched(NONE, 0, 0, 1, 0);
`else
    sched(sv(0, 0, 1, 0, 0, 6), 0, 1, 1, 0);
    sched(NONE, 0, 1, 1, 0);
`endif
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      o = observe();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL prio[%0d]: got %h want %h", i, o, e);
      end
      i++;
    end
    apply(NONE);
    reset = 1'b1;
    #1;
    o = observe();
    n_vec++;
    if (o !== obs_t'('0)) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", o, obs_t'('0));
    end
    tick();
    o = observe();
    n_vec++;
    if (o !== obs_t'('0)) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want %h", o, obs_t'('0));
    end
    reset = 1'b0;
    ref_cnt = '0;
    for (int k = 0; k < 6; k++) sched(NONE, 0, 0, 0, 0);
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      o = observe();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL post_reset[%0d]: got %h want %h", i, o, e);
      end
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    apply(NONE);
    test_reset();
    test_load_step();
    test_burst();
    test_burst_zero();
    test_run();
    test_fault();
    test_priority_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
